pc_hazard_ctrl: RTL
===================

PC_HAZARD_CTRL -- requirements
Module: pc_hazard_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 instr_id  input  32  instruction currently in ID stage.
REQ-005 ex_load  input  1  instruction in EX is lw (opcode 6'h23).
REQ-006 ex_rt  input  5  destination register of the EX-stage load.
REQ-007 br_taken  input  1  beq/bne in EX resolved taken this cycle.
REQ-008 pc_bubble  output  1  hold PC; drives the PC's isBubble.
REQ-009 id_flush  output  1  replace IF/ID contents with nop next edge.
REQ-010 ex_bubble  output  1  load nop into ID/EX next edge.
REQ-011 state  output  2  FSM state: RUN=0, LDSTALL=1, FLUSH=2, JRWAIT=3.
REQ-012 stall_cnt  output  16  count of cycles with pc_bubble=1.

Function
REQ-013 Decode from instr_id: op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0]; jr = (op==0 && funct==8).
REQ-014 "uses_rt" SHALL be true for op==0 (R-type, except jr), beq (4), bne (5) and sw (6'h2B); false otherwise.
REQ-015 load_use = ex_load && ex_rt!=0 && (ex_rt==rs || (uses_rt && ex_rt==rt)).
REQ-016 Outputs pc_bubble/id_flush/ex_bubble SHALL be combinational from state, wait counter and current inputs (same-cycle response); state/counters update at posedge.
REQ-017 Priority in every state: br_taken > load_use > jr.
REQ-018 RUN, br_taken: id_flush=1, ex_bubble=1, pc_bubble=0; next FLUSH.
REQ-019 RUN, load_use: pc_bubble=1, ex_bubble=1; next LDSTALL.
REQ-020 RUN, jr: pc_bubble=1, ex_bubble=1; wait_cnt<=1; next JRWAIT.
REQ-021 RUN, none: all outputs 0; stay RUN.
REQ-022 LDSTALL: br_taken handled as REQ-018; else re-evaluate instr_id as RUN (jr may enter JRWAIT); no second load stall unless load_use again holds.
REQ-023 FLUSH: id_flush=1, ex_bubble=0, pc_bubble=0 for exactly one cycle; br_taken here handled as REQ-018 (stay FLUSH); else next RUN.
REQ-024 JRWAIT: pc_bubble=1, ex_bubble=1; wait_cnt decrements; when wait_cnt==0 outputs 0 and next RUN. Total jr stall = 2 cycles.
REQ-025 JRWAIT, br_taken: abort wait, REQ-018 response, wait_cnt<=0, next FLUSH.
REQ-026 stall_cnt SHALL increment each cycle pc_bubble=1, saturating at 16'hFFFF (no wrap).
REQ-027 Unused state encodings are unreachable; if entered, next state RUN with outputs 0.

Reset
REQ-028 rst=1 at posedge: state<=RUN, wait_cnt<=0, stall_cnt<=0; rst dominates all inputs, including mid-JRWAIT/FLUSH.
REQ-029 While rst=1, pc_bubble, id_flush, ex_bubble SHALL be forced 0.

Structure
REQ-030 Opcode/funct constants (LW, SW, BEQ, BNE, J, JAL, R-type, JR funct) and state encodings SHALL live in a shared package/include used by the PC and decoder.
REQ-031 Decode (REQ-013..015) SHALL be one sub-module, hazard_decode, purely combinational; FSM and counters stay in pc_hazard_ctrl.

Verification
REQ-032 ex_load=1, ex_rt=5, instr_id=add $3,$5,$2 -> pc_bubble=ex_bubble=1 one cycle, state 0->1->0, stall_cnt=1.
REQ-033 ex_load=1, ex_rt=0, instr_id uses $0 -> no stall, state stays 0.
REQ-034 instr_id=jr $31 in RUN -> pc_bubble=1 exactly 2 cycles, state 0->3->3->0, stall_cnt+=2.
REQ-035 br_taken=1 with simultaneous load_use -> id_flush=ex_bubble=1, pc_bubble=0, next state 2; next cycle id_flush=1 only.
REQ-036 jr enters JRWAIT, br_taken=1 on first JRWAIT cycle -> state 2, pc_bubble=0; rst=1 mid-JRWAIT -> state 0, outputs 0, stall_cnt=0.
REQ-037 Hold load_use 70000 cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pc_hazard_ctrl_pkg.sv
// Shared MIPS opcode/funct constants, hazard FSM encodings and decode helpers
// used by the PC hazard controller and its instruction decoder.
package pc_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LDSTALL = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_JRWAIT  = 2'd3;

  // jr costs the entry cycle plus this many JRWAIT bubble cycles
  localparam logic [1:0]  JR_WAIT_INIT  = 2'd1;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic pc_bubble;
    logic id_flush;
    logic ex_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE  = '{pc_bubble: 1'b0, id_flush: 1'b0, ex_bubble: 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{pc_bubble: 1'b1, id_flush: 1'b0, ex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_BRANCH = '{pc_bubble: 1'b0, id_flush: 1'b1, ex_bubble: 1'b1};
  localparam hz_ctrl_t CTRL_FLUSH_TAIL = '{pc_bubble: 1'b0, id_flush: 1'b1, ex_bubble: 1'b0};

  // True when the instruction reads its rt field as a source operand.
  function automatic logic op_reads_rt(input logic [5:0] op, input logic is_jr);
    logic result;
    result = 1'b0;
    case (op)
      OP_RTYPE:              result = !is_jr;
      OP_BEQ, OP_BNE, OP_SW: result = 1'b1;
      OP_LW, OP_J, OP_JAL:   result = 1'b0;
      default:               result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic is_jr_instr(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && (funct == FN_JR);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational ID-stage decode: jr detection, rt usage and load-use hazard
// against the load currently in EX.
module hazard_decode
  import pc_hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic        i_ex_load,
  input  logic [4:0]  i_ex_rt,
  output logic        o_is_jr,
  output logic        o_uses_rt,
  output logic        o_load_use
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [5:0] w_funct;
  logic [9:0] w_unused_fields;
  logic       w_rs_hit;
  logic       w_rt_hit;

  assign w_op            = i_instr[31:26];
  assign w_rs            = i_instr[25:21];
  assign w_rt            = i_instr[20:16];
  assign w_funct         = i_instr[5:0];
  assign w_unused_fields = i_instr[15:6];

  assign o_is_jr   = is_jr_instr(w_op, w_funct);
  assign o_uses_rt = op_reads_rt(w_op, o_is_jr);

  // $0 is hardwired, so a load "into" it never creates a dependency
  assign w_rs_hit   = (i_ex_rt == w_rs);
  assign w_rt_hit   = o_uses_rt && (i_ex_rt == w_rt);
  assign o_load_use = i_ex_load && (i_ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pc_hazard_ctrl.sv
// Pipeline hazard FSM: load-use stalls, taken-branch flushes and jr waits,
// with a saturating count of PC-hold cycles.
module pc_hazard_ctrl
  import pc_hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_id,
  input  logic        ex_load,
  input  logic [4:0]  ex_rt,
  input  logic        br_taken,
  output logic        pc_bubble,
  output logic        id_flush,
  output logic        ex_bubble,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  logic [1:0]  r_state;
  logic [1:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;

  logic [1:0]  w_state_next;
  logic [1:0]  w_wait_next;
  hz_ctrl_t    w_ctrl;
  logic        w_is_jr;
  logic        w_uses_rt;
  logic        w_load_use;

  hazard_decode u_decode (
    .i_instr    (instr_id),
    .i_ex_load  (ex_load),
    .i_ex_rt    (ex_rt),
    .o_is_jr    (w_is_jr),
    .o_uses_rt  (w_uses_rt),
    .o_load_use (w_load_use)
  );

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_ctrl       = CTRL_NONE;
    case (r_state)
      ST_RUN, ST_LDSTALL: begin
        if (br_taken) begin
          w_ctrl       = CTRL_BRANCH;
          w_wait_next  = 2'd0;
          w_state_next = ST_FLUSH;
        end else if (w_load_use) begin
          w_ctrl       = CTRL_STALL;
          w_state_next = ST_LDSTALL;
        end else if (w_is_jr) begin
          w_ctrl       = CTRL_STALL;
          w_wait_next  = JR_WAIT_INIT;
          w_state_next = ST_JRWAIT;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (br_taken) begin
          w_ctrl       = CTRL_BRANCH;
          w_wait_next  = 2'd0;
          w_state_next = ST_FLUSH;
        end else begin
          w_ctrl       = CTRL_FLUSH_TAIL;
          w_state_next = ST_RUN;
        end
      end
      ST_JRWAIT: begin
        if (br_taken) begin
          w_ctrl       = CTRL_BRANCH;
          w_wait_next  = 2'd0;
          w_state_next = ST_FLUSH;
        end else if (r_wait_cnt != 2'd0) begin
          w_ctrl       = CTRL_STALL;
          w_wait_next  = r_wait_cnt - 2'd1;
          w_state_next = ST_JRWAIT;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_wait_next  = 2'd0;
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Reset masks the controls in the same cycle, before any state update
  assign pc_bubble = !rst && w_ctrl.pc_bubble;
  assign id_flush  = !rst && w_ctrl.id_flush;
  assign ex_bubble = !rst && w_ctrl.ex_bubble;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 2'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
      if (pc_bubble && (r_stall_cnt != STALL_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
